// File: rtl/cmp_mon_pkg.sv
// Shared types and helpers for the comparator result monitor.
// Optional flag checking is enabled with CMP_MON_CHECK_EN.
package cmp_mon_pkg;

  typedef enum logic {
    ACCUM,
    REPORT
  } state_t;

  typedef enum logic [1:0] {
    LT,
    GT,
    EQ
  } cls_t;

  // greater wins over lesser, anything else is EQ
  function automatic cls_t classify(
    input logic lesser,
    input logic greater
  );
    cls_t c;
    priority case (1'b1)
      greater: c = GT;
      lesser:  c = LT;
      default: c = EQ;
    endcase
    return c;
  endfunction

  function automatic logic onehot3(
    input logic [2:0] f
  );
    return (^f) & ~(&f);
  endfunction

endpackage

// File: rtl/cmp_run_detector.sv
// Tracks runs of identical outcome classes within a window and
// raises a sticky alarm once a run reaches RUN_LEN.
module cmp_run_detector
  import cmp_mon_pkg::*;
#(
  parameter int RUN_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic upd,
  input  cls_t cls,
  output logic run_alarm
);

  localparam int RW = $clog2(RUN_LEN + 1);

  logic [RW-1:0] run_cnt;
  logic [RW-1:0] run_nxt;
  cls_t          prev;
  logic          have_prev;

  always_comb begin
    run_nxt = run_cnt;
    if (!have_prev || cls != prev) begin
      run_nxt = RW'(1);
    end else if (run_cnt < RW'(RUN_LEN)) begin
      run_nxt = run_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt   <= '0;
      prev      <= EQ;
      have_prev <= 1'b0;
      run_alarm <= 1'b0;
    end else if (clr) begin
      run_cnt   <= '0;
      prev      <= EQ;
      have_prev <= 1'b0;
      run_alarm <= 1'b0;
    end else if (upd) begin
      run_cnt   <= run_nxt;
      prev      <= cls;
      have_prev <= 1'b1;
      if (run_nxt == RW'(RUN_LEN)) begin
        run_alarm <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmp_result_monitor.sv
// Windowed summary of comparator outcomes with valid/ready on both sides.
// Define CMP_MON_CHECK_EN to flag and skip samples with non-one-hot flags.
module cmp_result_monitor
  import cmp_mon_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int WINDOW  = 8,
  parameter int RUN_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic                       lesser,
  input  logic                       greater,
  input  logic                       equal,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WINDOW+1)-1:0] lt_cnt,
  output logic [$clog2(WINDOW+1)-1:0] gt_cnt,
  output logic [$clog2(WINDOW+1)-1:0] eq_cnt,
  output logic [WIDTH-1:0]           max_val,
  output logic                       run_alarm,
  output logic                       flag_err
);

  localparam int CW = $clog2(WINDOW + 1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   scnt;
  logic            accept;
  logic            last;
  logic            clr;
  logic            good;
  logic            upd;
  cls_t            cls;
  logic [WIDTH-1:0] smax;

  assign accept = in_valid && (state == ACCUM);
  assign last   = (scnt == CW'(WINDOW - 1));
  assign clr    = (state == REPORT) && out_ready;
  assign cls    = classify(lesser, greater);
  assign smax   = greater ? a : b;
  assign upd    = accept && good;

`ifdef CMP_MON_CHECK_EN
  assign good = onehot3({lesser, greater, equal});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_err <= 1'b0;
    end else if (clr) begin
      flag_err <= 1'b0;
    end else if (accept && !good) begin
      flag_err <= 1'b1;
    end
  end
`else
  logic unused_eq;

  assign good      = 1'b1;
  assign flag_err  = 1'b0;
  assign unused_eq = equal;
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && last) begin
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ACCUM;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // counts stay below WINDOW+1 since only WINDOW samples enter a window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt    <= '0;
      lt_cnt  <= '0;
      gt_cnt  <= '0;
      eq_cnt  <= '0;
      max_val <= '0;
    end else if (clr) begin
      scnt    <= '0;
      lt_cnt  <= '0;
      gt_cnt  <= '0;
      eq_cnt  <= '0;
      max_val <= '0;
    end else if (accept) begin
      scnt <= scnt + CW'(1);
      if (good) begin
        unique case (cls)
          LT:      lt_cnt <= lt_cnt + CW'(1);
          GT:      gt_cnt <= gt_cnt + CW'(1);
          default: eq_cnt <= eq_cnt + CW'(1);
        endcase
        if (smax > max_val) begin
          max_val <= smax;
        end
      end
    end
  end

  cmp_run_detector #(
    .RUN_LEN (RUN_LEN)
  ) u_run (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .upd       (upd),
    .cls       (cls),
    .run_alarm (run_alarm)
  );

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Table-driven bench with a summary scoreboard for cmp_result_monitor.
// Expected flag-check results follow CMP_MON_CHECK_EN.
module tb_cmp_result_monitor;

  localparam int WIDTH   = 16;
  localparam int WINDOW  = 4;
  localparam int RUN_LEN = 3;
  localparam int CW      = $clog2(WINDOW + 1);

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  f;
  } smp_t;

  typedef struct packed {
    logic [2:0]  lt;
    logic [2:0]  gt;
    logic [2:0]  eq;
    logic [15:0] mx;
    logic        alarm;
    logic        ferr;
  } sum_t;

  typedef struct packed {
    smp_t [3:0] s;
    sum_t       exp;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             lesser;
  logic             greater;
  logic             equal;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    lt_cnt;
  logic [CW-1:0]    gt_cnt;
  logic [CW-1:0]    eq_cnt;
  logic [WIDTH-1:0] max_val;
  logic             run_alarm;
  logic             flag_err;

  int   n_cmp;
  int   n_err;
  sum_t sb[$];
  vec_t vt[5];

  cmp_result_monitor #(
    .WIDTH   (WIDTH),
    .WINDOW  (WINDOW),
    .RUN_LEN (RUN_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .lesser    (lesser),
    .greater   (greater),
    .equal     (equal),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt_cnt    (lt_cnt),
    .gt_cnt    (gt_cnt),
    .eq_cnt    (eq_cnt),
    .max_val   (max_val),
    .run_alarm (run_alarm),
    .flag_err  (flag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 1);
    chk({tag, ".out_valid"}, 32'(out_valid), 0);
    chk({tag, ".lt"}, 32'(lt_cnt), 0);
    chk({tag, ".gt"}, 32'(gt_cnt), 0);
    chk({tag, ".eq"}, 32'(eq_cnt), 0);
    chk({tag, ".max"}, 32'(max_val), 0);
    chk({tag, ".alarm"}, 32'(run_alarm), 0);
    chk({tag, ".ferr"}, 32'(flag_err), 0);
  endtask

  task automatic check_sum(input string tag, input sum_t e);
    chk({tag, ".lt"}, 32'(lt_cnt), 32'(e.lt));
    chk({tag, ".gt"}, 32'(gt_cnt), 32'(e.gt));
    chk({tag, ".eq"}, 32'(eq_cnt), 32'(e.eq));
    chk({tag, ".max"}, 32'(max_val), 32'(e.mx));
    chk({tag, ".alarm"}, 32'(run_alarm), 32'(e.alarm));
    chk({tag, ".ferr"}, 32'(flag_err), 32'(e.ferr));
  endtask

  task automatic send(input smp_t s);
    in_valid = 1'b1;
    a        = s.a;
    b        = s.b;
    {lesser, greater, equal} = s.f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_win(input vec_t v);
    for (int j = 0; j < 4; j++) begin
      send(v.s[j]);
    end
    sb.push_back(v.exp);
  endtask

  task automatic wait_ov(input string tag);
    int k;
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, ".latency"}, 32'(k), 0);
  endtask

  task automatic take_summary(input string tag);
    sum_t e;
    wait_ov(tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 0);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'(sb.size()), 1);
      return;
    end
    e = sb.pop_front();
    check_sum(tag, e);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".post_ov"}, 32'(out_valid), 0);
    chk({tag, ".post_lt"}, 32'(lt_cnt), 0);
    chk({tag, ".post_max"}, 32'(max_val), 0);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    lesser    = 1'b0;
    greater   = 1'b0;
    equal     = 1'b0;

    vt[0].s[0] = '{a: 16'd2,    b: 16'd2,    f: 3'b001};
    vt[0].s[1] = '{a: 16'd44,   b: 16'd444,  f: 3'b100};
    vt[0].s[2] = '{a: 16'd555,  b: 16'd888,  f: 3'b100};
    vt[0].s[3] = '{a: 16'd8888, b: 16'd8888, f: 3'b001};
    vt[0].exp  = '{lt: 3'd2, gt: 3'd0, eq: 3'd2, mx: 16'd8888,
                   alarm: 1'b0, ferr: 1'b0};

    vt[1].s[0] = '{a: 16'd9, b: 16'd1, f: 3'b010};
    vt[1].s[1] = '{a: 16'd8, b: 16'd1, f: 3'b010};
    vt[1].s[2] = '{a: 16'd7, b: 16'd1, f: 3'b010};
    vt[1].s[3] = '{a: 16'd6, b: 16'd1, f: 3'b010};
    vt[1].exp  = '{lt: 3'd0, gt: 3'd4, eq: 3'd0, mx: 16'd9,
                   alarm: 1'b1, ferr: 1'b0};

    vt[2].s[0] = '{a: 16'd100,   b: 16'd50, f: 3'b010};
    vt[2].s[1] = '{a: 16'd7,     b: 16'd7,  f: 3'b001};
    vt[2].s[2] = '{a: 16'd3,     b: 16'd9,  f: 3'b100};
    vt[2].s[3] = '{a: 16'd65535, b: 16'd0,  f: 3'b010};
    vt[2].exp  = '{lt: 3'd1, gt: 3'd2, eq: 3'd1, mx: 16'd65535,
                   alarm: 1'b0, ferr: 1'b0};

    vt[3].s[0] = '{a: 16'd5, b: 16'd5, f: 3'b001};
    vt[3].s[1] = '{a: 16'd5, b: 16'd5, f: 3'b001};
    vt[3].s[2] = '{a: 16'd5, b: 16'd5, f: 3'b001};
    vt[3].s[3] = '{a: 16'd5, b: 16'd5, f: 3'b001};
    vt[3].exp  = '{lt: 3'd0, gt: 3'd0, eq: 3'd4, mx: 16'd5,
                   alarm: 1'b1, ferr: 1'b0};

    vt[4].s[0] = '{a: 16'd1,   b: 16'd10, f: 3'b100};
    vt[4].s[1] = '{a: 16'd2,   b: 16'd20, f: 3'b100};
    vt[4].s[2] = '{a: 16'd500, b: 16'd3,  f: 3'b110};
    vt[4].s[3] = '{a: 16'd4,   b: 16'd30, f: 3'b100};
`ifdef CMP_MON_CHECK_EN
    vt[4].exp  = '{lt: 3'd3, gt: 3'd0, eq: 3'd0, mx: 16'd30,
                   alarm: 1'b1, ferr: 1'b1};
`else
    vt[4].exp  = '{lt: 3'd3, gt: 3'd1, eq: 3'd0, mx: 16'd500,
                   alarm: 1'b0, ferr: 1'b0};
`endif

    repeat (2) @(posedge clk);
    #1;
    check_reset("rst0");
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      send_win(vt[i]);
      take_summary($sformatf("vec%0d", i));
    end

    // backpressure: summary held while inputs keep arriving
    send_win(vt[0]);
    wait_ov("bp");
    in_valid = 1'b1;
    a        = 16'd1000;
    b        = 16'd2000;
    {lesser, greater, equal} = 3'b100;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d.in_ready", c), 32'(in_ready), 0);
      chk($sformatf("bp%0d.out_valid", c), 32'(out_valid), 1);
      check_sum($sformatf("bp%0d", c), sb[0]);
    end
    in_valid = 1'b0;
    take_summary("bp_take");
    send_win(vt[1]);
    take_summary("bp_next");

    // reset mid-window discards partial samples
    send(vt[2].s[0]);
    send(vt[2].s[1]);
    rst = 1'b1;
    #2;
    check_reset("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_win(vt[3]);
    take_summary("rst_win");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
